// File: rtl/flag_unit_if.sv
// Flag interface between the EX/MEM pipeline control and the flag unit.
// The master drives the EX/MEM flag requests; the slave (flag_unit) returns forwarded and committed flags.
interface flag_unit_if;
  logic ex_valid;
  logic ex_c_we;
  logic ex_z_we;
  logic ex_carry;
  logic ex_zero;
  logic ex_commit;
  logic mem_ld_z_we;
  logic mem_ld_zero;
  logic stall;
  logic flush;
  logic fwd_carry;
  logic fwd_zero;
  logic arch_carry;
  logic arch_zero;
  logic flag_hazard;

  modport master (
    output ex_valid, ex_c_we, ex_z_we, ex_carry, ex_zero, ex_commit,
    output mem_ld_z_we, mem_ld_zero, stall, flush,
    input  fwd_carry, fwd_zero, arch_carry, arch_zero, flag_hazard
  );

  modport slave (
    input  ex_valid, ex_c_we, ex_z_we, ex_carry, ex_zero, ex_commit,
    input  mem_ld_z_we, mem_ld_zero, stall, flush,
    output fwd_carry, fwd_zero, arch_carry, arch_zero, flag_hazard
  );
endinterface

// File: rtl/flag_unit.sv
// Carry/zero flag pipeline (EX->MEM->WB->architected) with old-flag supply to EX.
// Build option FLAG_FWD_EN: defined = forward youngest pending flag; undefined = architected only plus flag_hazard.
module flag_unit #(
  parameter logic RESET_C = 1'b0,
  parameter logic RESET_Z = 1'b0
) (
  input logic        clk,
  input logic        reset,
  flag_unit_if.slave flg
);

  typedef struct packed {
    logic v;
    logic cwe;
    logic zwe;
    logic c;
    logic z;
  } flag_entry_t;

  localparam flag_entry_t ENTRY_EMPTY = '{v: 1'b0, cwe: 1'b0, zwe: 1'b0, c: 1'b0, z: 1'b0};

  flag_entry_t mem_r;
  flag_entry_t wb_r;
  logic        arch_c_r;
  logic        arch_z_r;

  flag_entry_t mem_nxt_s;
  flag_entry_t wb_nxt_s;
  logic        arch_c_nxt_s;
  logic        arch_z_nxt_s;
  logic        ld_z_upd_s;
  logic        fwd_c_s;
  logic        fwd_z_s;
  logic        hazard_s;

`ifdef FLAG_FWD_EN
  // Priority select: youngest pending producer first, architected value last.
  function automatic logic pick_flag(input logic we0, input logic val0,
                                     input logic we1, input logic val1,
                                     input logic arch);
    logic res;
    if (we0) begin
      res = val0;
    end else if (we1) begin
      res = val1;
    end else begin
      res = arch;
    end
    return res;
  endfunction
`endif

  assign ld_z_upd_s = mem_r.v & flg.mem_ld_z_we;

  // MEM entry next state: flush inserts a bubble even while stalled.
  always_comb begin
    mem_nxt_s = mem_r;
    if (flg.flush) begin
      mem_nxt_s = ENTRY_EMPTY;
    end else if (!flg.stall) begin
      mem_nxt_s.v   = flg.ex_valid;
      mem_nxt_s.cwe = flg.ex_valid & flg.ex_commit & flg.ex_c_we;
      mem_nxt_s.zwe = flg.ex_valid & flg.ex_commit & flg.ex_z_we;
      mem_nxt_s.c   = flg.ex_carry;
      mem_nxt_s.z   = flg.ex_zero;
    end else begin
      mem_nxt_s = mem_r;
    end
  end

  // WB entry next state: a load in MEM overrides the zero update it carries.
  always_comb begin
    wb_nxt_s = wb_r;
    if (!flg.stall) begin
      wb_nxt_s = mem_r;
      if (ld_z_upd_s) begin
        wb_nxt_s.zwe = 1'b1;
        wb_nxt_s.z   = flg.mem_ld_zero;
      end else begin
        wb_nxt_s.zwe = mem_r.zwe;
        wb_nxt_s.z   = mem_r.z;
      end
    end else begin
      wb_nxt_s = wb_r;
    end
  end

  // Architected flag commit from the WB entry.
  always_comb begin
    arch_c_nxt_s = arch_c_r;
    arch_z_nxt_s = arch_z_r;
    if (!flg.stall && wb_r.cwe) begin
      arch_c_nxt_s = wb_r.c;
    end else begin
      arch_c_nxt_s = arch_c_r;
    end
    if (!flg.stall && wb_r.zwe) begin
      arch_z_nxt_s = wb_r.z;
    end else begin
      arch_z_nxt_s = arch_z_r;
    end
  end

  // Flag pipeline and architected flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_r    <= ENTRY_EMPTY;
      wb_r     <= ENTRY_EMPTY;
      arch_c_r <= RESET_C;
      arch_z_r <= RESET_Z;
    end else begin
      mem_r    <= mem_nxt_s;
      wb_r     <= wb_nxt_s;
      arch_c_r <= arch_c_nxt_s;
      arch_z_r <= arch_z_nxt_s;
    end
  end

  // Old-flag values presented to EX and the associated hazard indication.
  always_comb begin
    fwd_c_s  = arch_c_r;
    fwd_z_s  = arch_z_r;
    hazard_s = 1'b0;
`ifdef FLAG_FWD_EN
    fwd_c_s = pick_flag(mem_r.cwe, mem_r.c, wb_r.cwe, wb_r.c, arch_c_r);
    if (ld_z_upd_s) begin
      fwd_z_s = flg.mem_ld_zero;
    end else begin
      fwd_z_s = pick_flag(mem_r.zwe, mem_r.z, wb_r.zwe, wb_r.z, arch_z_r);
    end
    hazard_s = 1'b0;
`else
    fwd_c_s  = arch_c_r;
    fwd_z_s  = arch_z_r;
    hazard_s = mem_r.cwe | mem_r.zwe | wb_r.cwe | wb_r.zwe | ld_z_upd_s;
`endif
  end

  assign flg.fwd_carry   = fwd_c_s;
  assign flg.fwd_zero    = fwd_z_s;
  assign flg.arch_carry  = arch_c_r;
  assign flg.arch_zero   = arch_z_r;
  assign flg.flag_hazard = hazard_s;

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit; expectations adapt to the FLAG_FWD_EN build.
module tb_flag_unit;

`ifdef FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  flag_unit_if bus ();

  flag_unit #(.RESET_C(1'b1), .RESET_Z(1'b0)) dut (
    .clk  (clk),
    .reset(reset),
    .flg  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid    = 1'b0;
    bus.ex_c_we     = 1'b0;
    bus.ex_z_we     = 1'b0;
    bus.ex_carry    = 1'b0;
    bus.ex_zero     = 1'b0;
    bus.ex_commit   = 1'b0;
    bus.mem_ld_z_we = 1'b0;
    bus.mem_ld_zero = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
  endtask

  task automatic writer(input logic c, input logic z, input logic commit);
    bus.ex_valid  = 1'b1;
    bus.ex_c_we   = 1'b1;
    bus.ex_z_we   = 1'b1;
    bus.ex_carry  = c;
    bus.ex_zero   = z;
    bus.ex_commit = commit;
  endtask

  task automatic set_flags(input logic c, input logic z);
    writer(c, z, 1'b1);
    step();
    idle();
    step();
    step();
    step();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #3;
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL rst_arch_c got=%b exp=1", bus.arch_carry); end
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL rst_arch_z got=%b exp=0", bus.arch_zero); end
    tests++; if (bus.fwd_carry !== 1'b1) begin fails++; $display("FAIL rst_fwd_c got=%b exp=1", bus.fwd_carry); end
    tests++; if (bus.fwd_zero !== 1'b0) begin fails++; $display("FAIL rst_fwd_z got=%b exp=0", bus.fwd_zero); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL rst_hazard got=%b exp=0", bus.flag_hazard); end
    @(negedge clk);
    reset = 1'b0;
    writer(1'b0, 1'b1, 1'b1);
    step();
    idle();
    tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL pend_hazard got=%b exp=%b", bus.flag_hazard, !FWD); end
    tests++; if (bus.fwd_carry !== !FWD) begin fails++; $display("FAIL pend_fwd_c got=%b exp=%b", bus.fwd_carry, !FWD); end
    tests++; if (bus.fwd_zero !== FWD) begin fails++; $display("FAIL pend_fwd_z got=%b exp=%b", bus.fwd_zero, FWD); end
    #3;
    reset = 1'b1;
    #1;
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL midrst_arch_c got=%b exp=1", bus.arch_carry); end
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL midrst_arch_z got=%b exp=0", bus.arch_zero); end
    tests++; if (bus.fwd_carry !== 1'b1) begin fails++; $display("FAIL midrst_fwd_c got=%b exp=1", bus.fwd_carry); end
    tests++; if (bus.fwd_zero !== 1'b0) begin fails++; $display("FAIL midrst_fwd_z got=%b exp=0", bus.fwd_zero); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL midrst_hazard got=%b exp=0", bus.flag_hazard); end
    step();
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    step();
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL postrst_arch_c got=%b exp=1", bus.arch_carry); end
  endtask

  task automatic test_add();
    set_flags(1'b0, 1'b1);
    writer(1'b1, 1'b0, 1'b1);
    step();
    idle();
    tests++; if (bus.fwd_carry !== FWD) begin fails++; $display("FAIL add_fwd_c_n1 got=%b exp=%b", bus.fwd_carry, FWD); end
    tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL add_arch_c_n1 got=%b exp=0", bus.arch_carry); end
    tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL add_hazard_n1 got=%b exp=%b", bus.flag_hazard, !FWD); end
    step();
    tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL add_arch_c_n2 got=%b exp=0", bus.arch_carry); end
    tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL add_hazard_n2 got=%b exp=%b", bus.flag_hazard, !FWD); end
    step();
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL add_arch_c_n3 got=%b exp=1", bus.arch_carry); end
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL add_arch_z_n3 got=%b exp=0", bus.arch_zero); end
    tests++; if (bus.fwd_carry !== 1'b1) begin fails++; $display("FAIL add_fwd_c_n3 got=%b exp=1", bus.fwd_carry); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL add_hazard_n3 got=%b exp=0", bus.flag_hazard); end
  endtask

  task automatic test_cancel();
    set_flags(1'b0, 1'b0);
    writer(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      idle();
      tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL cancel_arch_c n+%0d got=%b exp=0", i, bus.arch_carry); end
      tests++; if (bus.fwd_carry !== 1'b0) begin fails++; $display("FAIL cancel_fwd_c n+%0d got=%b exp=0", i, bus.fwd_carry); end
      tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL cancel_hazard n+%0d got=%b exp=0", i, bus.flag_hazard); end
    end
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL cancel_arch_z got=%b exp=0", bus.arch_zero); end
  endtask

  task automatic test_lw_back_to_back();
    set_flags(1'b0, 1'b0);
    bus.ex_valid = 1'b1;
    step();
    idle();
    bus.ex_valid    = 1'b1;
    bus.ex_z_we     = 1'b1;
    bus.ex_commit   = 1'b1;
    bus.ex_zero     = 1'b0;
    bus.mem_ld_z_we = 1'b1;
    bus.mem_ld_zero = 1'b1;
    #1;
    tests++; if (bus.fwd_zero !== FWD) begin fails++; $display("FAIL lw_fwd_z got=%b exp=%b", bus.fwd_zero, FWD); end
    tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL lw_hazard got=%b exp=%b", bus.flag_hazard, !FWD); end
    step();
    idle();
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL lw_arch_z_e1 got=%b exp=0", bus.arch_zero); end
    tests++; if (bus.fwd_zero !== 1'b0) begin fails++; $display("FAIL lw_fwd_z_e1 got=%b exp=0", bus.fwd_zero); end
    step();
    tests++; if (bus.arch_zero !== 1'b1) begin fails++; $display("FAIL lw_arch_z_e2 got=%b exp=1", bus.arch_zero); end
    tests++; if (bus.fwd_zero !== !FWD) begin fails++; $display("FAIL lw_fwd_z_e2 got=%b exp=%b", bus.fwd_zero, !FWD); end
    step();
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL b2b_arch_z got=%b exp=0", bus.arch_zero); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL b2b_hazard got=%b exp=0", bus.flag_hazard); end
  endtask

  task automatic test_flush();
    set_flags(1'b0, 1'b0);
    writer(1'b1, 1'b1, 1'b1);
    bus.flush = 1'b1;
    step();
    idle();
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL flush_hazard got=%b exp=0", bus.flag_hazard); end
    tests++; if (bus.fwd_carry !== 1'b0) begin fails++; $display("FAIL flush_fwd_c got=%b exp=0", bus.fwd_carry); end
    step();
    step();
    step();
    tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL flush_arch_c got=%b exp=0", bus.arch_carry); end
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL flush_arch_z got=%b exp=0", bus.arch_zero); end
  endtask

  task automatic test_stall();
    set_flags(1'b0, 1'b0);
    writer(1'b1, 1'b1, 1'b1);
    step();
    writer(1'b0, 1'b0, 1'b1);
    bus.stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL stall_arch_c s%0d got=%b exp=0", i, bus.arch_carry); end
      tests++; if (bus.fwd_carry !== FWD) begin fails++; $display("FAIL stall_fwd_c s%0d got=%b exp=%b", i, bus.fwd_carry, FWD); end
      tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL stall_hazard s%0d got=%b exp=%b", i, bus.flag_hazard, !FWD); end
    end
    idle();
    step();
    tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL stall_arch_c r1 got=%b exp=0", bus.arch_carry); end
    tests++; if (bus.fwd_carry !== FWD) begin fails++; $display("FAIL stall_fwd_c r1 got=%b exp=%b", bus.fwd_carry, FWD); end
    step();
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL stall_arch_c r2 got=%b exp=1", bus.arch_carry); end
    tests++; if (bus.arch_zero !== 1'b1) begin fails++; $display("FAIL stall_arch_z r2 got=%b exp=1", bus.arch_zero); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL stall_hazard r2 got=%b exp=0", bus.flag_hazard); end
  endtask

  task automatic test_stall_flush();
    set_flags(1'b0, 1'b0);
    writer(1'b1, 1'b0, 1'b1);
    step();
    idle();
    step();
    writer(1'b1, 1'b1, 1'b1);
    bus.stall = 1'b1;
    bus.flush = 1'b1;
    step();
    tests++; if (bus.arch_carry !== 1'b0) begin fails++; $display("FAIL sf_arch_c_hold got=%b exp=0", bus.arch_carry); end
    tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL sf_hazard got=%b exp=%b", bus.flag_hazard, !FWD); end
    idle();
    step();
    tests++; if (bus.arch_carry !== 1'b1) begin fails++; $display("FAIL sf_arch_c_commit got=%b exp=1", bus.arch_carry); end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL sf_hazard_clear got=%b exp=0", bus.flag_hazard); end
    step();
    step();
    tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL sf_arch_z got=%b exp=0", bus.arch_zero); end
  endtask

  task automatic test_hazard();
    set_flags(1'b0, 1'b0);
    writer(1'b0, 1'b1, 1'b1);
    step();
    idle();
    for (int i = 1; i <= 2; i++) begin
      tests++; if (bus.flag_hazard !== !FWD) begin fails++; $display("FAIL hz_hazard c%0d got=%b exp=%b", i, bus.flag_hazard, !FWD); end
      tests++; if (bus.fwd_zero !== FWD) begin fails++; $display("FAIL hz_fwd_z c%0d got=%b exp=%b", i, bus.fwd_zero, FWD); end
      tests++; if (bus.arch_zero !== 1'b0) begin fails++; $display("FAIL hz_arch_z c%0d got=%b exp=0", i, bus.arch_zero); end
      step();
    end
    tests++; if (bus.flag_hazard !== 1'b0) begin fails++; $display("FAIL hz_hazard_done got=%b exp=0", bus.flag_hazard); end
    tests++; if (bus.fwd_zero !== 1'b1) begin fails++; $display("FAIL hz_fwd_z_done got=%b exp=1", bus.fwd_zero); end
    tests++; if (bus.arch_zero !== 1'b1) begin fails++; $display("FAIL hz_arch_z_done got=%b exp=1", bus.arch_zero); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    idle();
    test_reset();
    test_add();
    test_cancel();
    test_lw_back_to_back();
    test_flush();
    test_stall();
    test_stall_flush();
    test_hazard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
